// File: rtl/vga_pkg.sv
// Shared VGA pixel-clock types, resolution ratios and board constants.
// Imported by the pixel-rate generator and its fractional strobe core.
package vga_pkg;

  localparam int unsigned CLK_100M_HZ = 100_000_000;

  typedef enum logic [1:0] {
    VGA_RES_640_480   = 2'd0,
    VGA_RES_800_600   = 2'd1,
    VGA_RES_1024_768  = 2'd2,
    VGA_RES_1280_1024 = 2'd3
  } vga_resolution_e;

  typedef struct packed {
    logic [4:0] n;
    logic [4:0] d;
  } vga_ratio_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOCK,
    ST_RUN
  } pclk_state_e;

  function automatic vga_ratio_t vga_res_ratio(
    input vga_resolution_e res
  );
    vga_ratio_t r;
    case (res)
      VGA_RES_640_480:   r = '{n: 5'd1,  d: 5'd4};
      VGA_RES_800_600:   r = '{n: 5'd2,  d: 5'd5};
      VGA_RES_1024_768:  r = '{n: 5'd13, d: 5'd20};
      VGA_RES_1280_1024: r = '{n: 5'd1,  d: 5'd1};
      default:           r = '{n: 5'd1,  d: 5'd4};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/vga_frac_strobe.sv
// N/D fractional-rate strobe: emits one-cycle pulses averaging n/d
// of the input clock, with the first pulse on the first cycle after load.
module vga_frac_strobe
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [4:0] n,
  input  logic [4:0] d,
  output logic       strobe
);

  logic [4:0] acc;
  logic [5:0] sum;

  assign sum = {1'b0, acc} + {1'b0, n};

  // Preloading d-n makes the first post-load sum hit d exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      strobe <= 1'b0;
    end else if (load) begin
      acc    <= d - n;
      strobe <= 1'b0;
    end else if (sum >= {1'b0, d}) begin
      acc    <= acc + n - d;
      strobe <= 1'b1;
    end else begin
      acc    <= acc + n;
      strobe <= 1'b0;
    end
  end

endmodule

// File: rtl/vga_pixel_clk_gen.sv
// Pixel-rate generator: request edge detect, settle counter and FSM
// around the fractional strobe core.
module vga_pixel_clk_gen
  import vga_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 64
) (
  input  logic            clk_100m_i,
  input  logic            rst_i,
  input  vga_resolution_e resolution_i,
  input  logic            req_i,
  output logic            clk_o,
  output logic            valid_o
);

  localparam logic [15:0] LOCK_LOAD = 16'(LOCK_CYCLES - 1);

  pclk_state_e state, state_next;
  logic        req_q;
  logic        accept;
  logic        load;
  logic [15:0] cnt;
  vga_ratio_t  ratio_q;

  assign accept = req_i & ~req_q;
  assign load   = accept | (state != ST_RUN);

  always_ff @(posedge clk_100m_i) begin
    if (rst_i) begin
      req_q   <= 1'b0;
      state   <= ST_IDLE;
      cnt     <= '0;
      ratio_q <= '0;
      valid_o <= 1'b0;
    end else begin
      req_q   <= req_i;
      state   <= state_next;
      valid_o <= (state == ST_RUN) && !accept;
      if (accept) begin
        ratio_q <= vga_res_ratio(resolution_i);
        cnt     <= LOCK_LOAD;
      end else if (state == ST_LOCK && cnt != '0) begin
        cnt <= cnt - 16'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: if (accept) state_next = ST_LOCK;
      ST_LOCK: begin
        if (accept)         state_next = ST_LOCK;
        else if (cnt == '0) state_next = ST_RUN;
      end
      ST_RUN:  if (accept) state_next = ST_LOCK;
      default: state_next = ST_IDLE;
    endcase
  end

  vga_frac_strobe u_frac (
    .clk    (clk_100m_i),
    .rst    (rst_i),
    .load   (load),
    .n      (ratio_q.n),
    .d      (ratio_q.d),
    .strobe (clk_o)
  );

endmodule

// File: tb/tb_vga_pixel_clk_gen.sv
// Scoreboard bench for vga_pixel_clk_gen.
// Expected {valid_o,clk_o} per cycle is queued as stimulus is driven.
module tb_vga_pixel_clk_gen;
  import vga_pkg::*;

  localparam int L = 64;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req = 1'b0;
  vga_resolution_e res = VGA_RES_640_480;
  logic            clk_o;
  logic            valid_o;

  int n_run   = 0;
  int n_fail  = 0;
  int strobes = 0;
  int run_k   = 0;
  int run_n   = 1;
  int run_d   = 4;

  logic [1:0] sb[$];

  always #5 clk = ~clk;

  vga_pixel_clk_gen #(.LOCK_CYCLES(L)) dut (
    .clk_100m_i   (clk),
    .rst_i        (rst),
    .resolution_i (res),
    .req_i        (req),
    .clk_o        (clk_o),
    .valid_o      (valid_o)
  );

  task automatic check(string tag, int got, int want);
    n_run++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic strobe_at(int k, int n, int d);
    if (k == 0) return 1'b1;
    return ((k * n) / d) != (((k - 1) * n) / d);
  endfunction

  task automatic set_ratio(vga_resolution_e r);
    case (r)
      VGA_RES_640_480:  begin run_n = 1;  run_d = 4;  end
      VGA_RES_800_600:  begin run_n = 2;  run_d = 5;  end
      VGA_RES_1024_768: begin run_n = 13; run_d = 20; end
      default:          begin run_n = 1;  run_d = 1;  end
    endcase
  endtask

  task automatic cyc(string tag);
    logic [1:0] e;
    @(negedge clk);
    if (clk_o) strobes++;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check(tag, int'({valid_o, clk_o}), int'(e));
    end
  endtask

  task automatic drain(string tag);
    while (sb.size() != 0) cyc(tag);
  endtask

  task automatic expect_lock();
    repeat (L + 1) sb.push_back(2'b00);
    run_k = 0;
  endtask

  task automatic expect_run(int cycles);
    for (int i = 0; i < cycles; i++) begin
      sb.push_back({1'b1, strobe_at(run_k, run_n, run_d)});
      run_k++;
    end
  endtask

  task automatic request(vga_resolution_e r, string tag);
    res = r;
    req = 1'b1;
    set_ratio(r);
    expect_lock();
    cyc(tag);
    req = 1'b0;
  endtask

  task automatic rate(vga_resolution_e r, int want, string tag);
    request(r, tag);
    drain(tag);
    strobes = 0;
    expect_run(1000);
    drain(tag);
    check({tag, "_cnt"}, strobes, want);
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b1;
    res = VGA_RES_1280_1024;
    repeat (3) @(negedge clk);
    check("rst_valid", int'(valid_o), 0);
    check("rst_clk", int'(clk_o), 0);

    rst = 1'b0;
    set_ratio(VGA_RES_1280_1024);
    expect_lock();
    expect_run(20);
    drain("p1_full");
    req = 1'b0;
    expect_run(20);
    drain("p1_hold");

    rate(VGA_RES_640_480,  250, "r640");
    rate(VGA_RES_800_600,  400, "r800");
    rate(VGA_RES_1024_768, 650, "r1024");

    request(VGA_RES_640_480, "p4_a");
    drain("p4_a");
    expect_run(10);
    drain("p4_a");
    request(VGA_RES_800_600, "p4_sw");
    drain("p4_sw");
    expect_run(20);
    drain("p4_sw");
    res = VGA_RES_1280_1024;
    expect_run(20);
    drain("p4_ign");

    request(VGA_RES_1024_768, "p5_a");
    repeat (L / 2) cyc("p5_a");
    sb.delete();
    request(VGA_RES_1024_768, "p5_b");
    drain("p5_b");
    expect_run(40);
    drain("p5_b");

    rst = 1'b1;
    sb.delete();
    repeat (3) sb.push_back(2'b00);
    drain("p6_rst");
    rst = 1'b0;
    repeat (20) sb.push_back(2'b00);
    drain("p6_idle");
    request(VGA_RES_800_600, "p6_re");
    expect_run(15);
    drain("p6_re");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
